// File: rtl/net_pkg.sv
// net_pkg: definitions shared between payload_burster and network_stack.
//   PAYLOAD_W        payload word width used on the axiiv/axiid interface
//   burster_state_t  payload_burster sequencing states
package net_pkg;

    localparam int unsigned PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } burster_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and an occupancy count.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset (pointers and level only)
//   wr       in   write strobe; caller guarantees !full
//   wr_data  in   WIDTH   word to write
//   rd       in   read strobe; caller guarantees !empty
//   rd_data  out  WIDTH   word at the head (valid while !empty)
//   full     out  level == DEPTH
//   empty    out  level == 0
//   level    out  $clog2(DEPTH)+1   words stored, updated the cycle after wr/rd
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/payload_burster.sv
// payload_burster: buffers a free-running payload word stream and replays it
// as contiguous bursts (one per UDP frame) into network_stack, with an idle
// gap after each burst so the frame is serialised before the next starts.
// Ports:
//   clk        in   eth_refclk
//   rst        in   asynchronous active-low reset
//   in_valid   in   producer word strobe
//   in_data    in   DATA_SIZE  producer word
//   in_ready   out  buffer can accept a word this cycle
//   flush      in   pulse: send buffered words even if fewer than BURST_WORDS
//   axiov      out  burst word valid (to network_stack axiiv)
//   axiod      out  DATA_SIZE  burst word (to network_stack axiid)
//   busy       out  sequencer not idle
//   overflow   out  sticky: a word offered while full was dropped
//   level      out  $clog2(FIFO_DEPTH)+1  words currently buffered
module payload_burster
    import net_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = PAYLOAD_W,
    parameter int unsigned BURST_WORDS = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned GAP_CYCLES  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_SIZE-1:0]          in_data,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          axiov,
    output logic [DATA_SIZE-1:0]          axiod,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [LW-1:0] BURST_LVL = LW'(BURST_WORDS);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    burster_state_t         state, state_nxt;
    logic [LW-1:0]          len, len_nxt;
    logic [GW-1:0]          gap_cnt, gap_nxt;
    logic                   axiov_nxt;
    logic [DATA_SIZE-1:0]   axiod_nxt;
    logic                   flush_pending;
    logic                   flush_clr;
    logic                   start;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [DATA_SIZE-1:0]   head;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE);

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (push),
        .wr_data (in_data),
        .rd      (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // The first word is popped on the IDLE->BURST decision edge so that axiov
    // rises one cycle after the decision; len then holds the words still to
    // send after the one currently on axiod.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        gap_nxt   = gap_cnt;
        axiov_nxt = 1'b0;
        axiod_nxt = axiod;
        pop       = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (level >= BURST_LVL) begin
                    start   = 1'b1;
                    len_nxt = BURST_LVL - LW'(1);
                end else if (flush_pending && !empty) begin
                    start   = 1'b1;
                    len_nxt = level - LW'(1);
                end
                if (start) begin
                    pop       = 1'b1;
                    axiov_nxt = 1'b1;
                    axiod_nxt = head;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (len != '0) begin
                    pop       = 1'b1;
                    axiov_nxt = 1'b1;
                    axiod_nxt = head;
                    len_nxt   = len - LW'(1);
                end else begin
                    gap_nxt   = GAP_LAST;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - GW'(1);
            end
            default: state_nxt = IDLE;
        endcase
        flush_clr = start || (state == IDLE && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            len           <= '0;
            gap_cnt       <= '0;
            axiov         <= 1'b0;
            axiod         <= '0;
            flush_pending <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_nxt;
            len           <= len_nxt;
            gap_cnt       <= gap_nxt;
            axiov         <= axiov_nxt;
            axiod         <= axiod_nxt;
            // A new flush pulse wins over a same-cycle clear.
            flush_pending <= flush || (flush_pending && !flush_clr);
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_payload_burster.sv
module tb_payload_burster;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, in_ready, axiov, busy, overflow;
    logic [15:0] in_data, axiod;
    logic [5:0]  level;

    logic        b_in_valid, b_flush, b_in_ready, b_axiov, b_busy, b_overflow;
    logic [15:0] b_in_data, b_axiod;
    logic [5:0]  b_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_push;

    logic [15:0] exp_q[$];
    logic [15:0] out_q[$];
    logic [15:0] b_exp_q[$];
    logic [15:0] b_out_q[$];
    int          rise_q[$];
    int          fall_q[$];
    logic        prev_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    payload_burster u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .axiov(axiov), .axiod(axiod),
        .busy(busy), .overflow(overflow), .level(level)
    );

    payload_burster #(
        .DATA_SIZE(16), .BURST_WORDS(32), .FIFO_DEPTH(32), .GAP_CYCLES(4)
    ) u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .flush(b_flush), .axiov(b_axiov), .axiod(b_axiod),
        .busy(b_busy), .overflow(b_overflow), .level(b_level)
    );

    always @(negedge clk) begin
        if (axiov) out_q.push_back(axiod);
        if (axiov && !prev_v) rise_q.push_back(cyc);
        if (!axiov && prev_v) fall_q.push_back(cyc);
        prev_v <= axiov;
        if (b_axiov) b_out_q.push_back(b_axiod);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        last_push = cyc;
        exp_q.push_back(d);
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic b_push_word(input logic [15:0] d);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_exp_q.push_back(d);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_qs();
        exp_q.delete();
        out_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (i < out_q.size()) ? out_q[i] : 16'hxxxx, exp_q[i]);
        end
    endtask

    initial begin
        int f;
        int rise0;
        logic [15:0] t1_words [8];
        t1_words = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420,
                     16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0;
        wait_cycles(3);
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        wait_cycles(2);

        // 1. full burst
        clear_qs();
        for (int i = 0; i < 8; i++) push_word(t1_words[i]);
        check("t1_level_after_fill", level, 8);
        check("t1_busy_decision", busy, 0);
        wait_cycles(1);
        check("t1_busy_burst", busy, 1);
        wait_cycles(15);
        compare_stream("t1");
        check("t1_w0_const", out_q.size() > 0 ? out_q[0] : 16'hxxxx, 16'hABCD);
        check("t1_w7_const", out_q.size() > 7 ? out_q[7] : 16'hxxxx, 16'h4444);
        check("t1_rise", rise_q.size() > 0 ? rise_q[0] : -1, last_push + 2);
        check("t1_fall", fall_q.size() > 0 ? fall_q[0] : -1, last_push + 10);
        check("t1_level_end", level, 0);
        wait_cycles(80);

        // 2. flush
        clear_qs();
        push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
        wait_cycles(5);
        check("t2_no_early_burst", out_q.size(), 0);
        f = cyc;
        flush = 1'b1; wait_cycles(1); flush = 1'b0;
        wait_cycles(10);
        compare_stream("t2");
        check("t2_rise", rise_q.size() > 0 ? rise_q[0] : -1, f + 2);
        check("t2_len", (fall_q.size() > 0 && rise_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, 3);
        wait_cycles(80);
        clear_qs();
        flush = 1'b1; wait_cycles(1); flush = 1'b0;
        wait_cycles(10);
        check("t2_empty_flush_no_axiov", out_q.size(), 0);
        check("t2_empty_flush_idle", busy, 0);

        // 3 + 5. gap between two bursts, pushes continuing through a burst
        clear_qs();
        for (int i = 0; i < 16; i++) begin
            push_word(16'h3000 + 16'(i));
            if (i >= 7) check($sformatf("t5_level_c%0d", i), level, 8);
        end
        wait_cycles(200);
        compare_stream("t3");
        check("t3_bursts", rise_q.size(), 2);
        check("t3_gap", (rise_q.size() > 1 && fall_q.size() > 0) ? ((rise_q[1] - fall_q[0]) >= 65) : 0, 1);
        check("t3_len0", (fall_q.size() > 0 && rise_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, 8);
        check("t3_level_end", level, 0);

        // 4. overflow on a 32-deep, 32-word-burst instance
        for (int i = 0; i < 32; i++) b_push_word(16'h5000 + 16'(i));
        check("t4_level_full", b_level, 32);
        check("t4_in_ready_full", b_in_ready, 0);
        check("t4_overflow_before", b_overflow, 0);
        b_in_valid = 1'b1; b_in_data = 16'hDEAD;
        wait_cycles(1);
        b_in_valid = 1'b0;
        check("t4_overflow_set", b_overflow, 1);
        wait_cycles(50);
        check("t4_count", b_out_q.size(), 32);
        for (int i = 0; i < 32; i++)
            check($sformatf("t4_w%0d", i), (i < b_out_q.size()) ? b_out_q[i] : 16'hxxxx, b_exp_q[i]);
        check("t4_overflow_sticky", b_overflow, 1);

        // 6. reset during the 4th burst word
        clear_qs();
        for (int i = 0; i < 8; i++) push_word(16'h6000 + 16'(i));
        rise0 = last_push + 2;
        wait_cycles(rise0 + 3 - cyc);
        check("t6_mid_burst_axiov", axiov, 1);
        check("t6_mid_burst_word", axiod, 16'h6003);
        rst = 1'b0;
        #1;
        check("t6_rst_axiov", axiov, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_big_overflow", b_overflow, 0);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);
        clear_qs();
        for (int i = 0; i < 8; i++) push_word(16'h7000 + 16'(i));
        wait_cycles(15);
        compare_stream("t6");
        check("t6_rise", rise_q.size() > 0 ? rise_q[0] : -1, last_push + 2);
        check("t6_level_end", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
